// File: rtl/mem_pattern_tester.sv
// Write-then-verify memory tester: fills 0..ADDR_LAST with one of four patterns over a
// single-outstanding req/ack port, reads it back and accumulates pass/fail statistics.
module mem_pattern_tester #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 22,
    parameter logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}},
    parameter logic [31:0]       LFSR_SEED = 32'hACE1_2461
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       passcount,
    output logic [31:0]       failcount,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_xor,
    output logic [2:0]        state
);

    localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
    localparam int unsigned       SUM_W     = ADDR_W + 33;
    localparam logic [SUM_W-1:0]  DW_MOD    = SUM_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        md,
        input logic [ADDR_W-1:0] a,
        input logic [31:0]       p,
        input logic [31:0]       l
    );
        logic [ADDR_W+DATA_W-1:0] a_ext;
        logic [SUM_W-1:0]         sum;
        logic [DATA_W-1:0]        cb;
        logic [DATA_W-1:0]        r;
        a_ext = {{DATA_W{1'b0}}, a};
        sum   = {{33{1'b0}}, a} + {{(ADDR_W+1){1'b0}}, p};
        for (int i = 0; i < int'(DATA_W); i++) cb[i] = ((i % 2) == 0);
        case (md)
            2'd0:    r = a_ext[DATA_W-1:0] ^ {DATA_W{p[0]}};
            2'd1:    r = l[DATA_W-1:0];
            2'd2:    r = DATA_W'(1) << (sum % DW_MOD);
            default: r = cb ^ {DATA_W{a[0] ^ p[0]}};
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [31:0]         lfsr_base_q, lfsr_base_d;
    logic [31:0]         pass_idx_q, pass_idx_d;
    logic                pass_bad_q, pass_bad_d;
    logic [31:0]         passcount_q, passcount_d;
    logic [31:0]         failcount_q, failcount_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_xor_q, fail_xor_d;

    logic                acked;
    logic                at_last;
    logic [DATA_W-1:0]   expected;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        req_d       = req_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        lfsr_d      = lfsr_q;
        lfsr_base_d = lfsr_base_q;
        pass_idx_d  = pass_idx_q;
        pass_bad_d  = pass_bad_q;
        passcount_d = passcount_q;
        failcount_d = failcount_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_xor_d  = fail_xor_q;

        // An ack only counts against an outstanding request.
        acked    = mem_ack && req_q;
        at_last  = (addr_q == ADDR_LAST);
        expected = pattern(mode_q, addr_q, pass_idx_q, lfsr_q);

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WRITE;
                    mode_d  = mode;
                    addr_d  = '0;
                    lfsr_d  = lfsr_base_q;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                end
            end
            S_WRITE: begin
                if (acked) begin
                    if (!enable) begin
                        state_d    = S_IDLE;
                        req_d      = 1'b0;
                        we_d       = 1'b0;
                        pass_bad_d = 1'b0;
                    end else if (at_last) begin
                        state_d = S_READ;
                        addr_d  = '0;
                        lfsr_d  = lfsr_base_q;
                        we_d    = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                end
            end
            S_READ: begin
                if (acked) begin
                    if (mem_rdata != expected) begin
                        pass_bad_d = 1'b1;
                        if (failcount_q != 32'hFFFF_FFFF) failcount_d = failcount_q + 32'd1;
                        if (!err_q) begin
                            err_d       = 1'b1;
                            fail_addr_d = addr_q;
                            fail_xor_d  = expected ^ mem_rdata;
                        end
                    end
                    // Finishing the last read completes the pass even if enable just fell.
                    if (at_last) begin
                        state_d = S_CHECK;
                        req_d   = 1'b0;
                    end else if (!enable) begin
                        state_d    = S_IDLE;
                        req_d      = 1'b0;
                        pass_bad_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                end
            end
            S_CHECK: begin
                if (!pass_bad_q && passcount_q != 32'hFFFF_FFFF) passcount_d = passcount_q + 32'd1;
                pass_bad_d  = 1'b0;
                pass_idx_d  = pass_idx_q + 32'd1;
                lfsr_base_d = lfsr_step(lfsr_base_q);
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

        // Write data follows the next address; unchanged while a write waits for its ack.
        if (state_d == S_WRITE) wdata_d = pattern(mode_d, addr_d, pass_idx_q, lfsr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            addr_q      <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            lfsr_base_q <= LFSR_SEED;
            pass_idx_q  <= 32'd0;
            pass_bad_q  <= 1'b0;
            passcount_q <= 32'd0;
            failcount_q <= 32'd0;
            err_q       <= 1'b0;
            fail_addr_q <= '0;
            fail_xor_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            lfsr_q      <= lfsr_d;
            lfsr_base_q <= lfsr_base_d;
            pass_idx_q  <= pass_idx_d;
            pass_bad_q  <= pass_bad_d;
            passcount_q <= passcount_d;
            failcount_q <= failcount_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_xor_q  <= fail_xor_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign passcount  = passcount_q;
    assign failcount  = failcount_q;
    assign err_sticky = err_q;
    assign fail_addr  = fail_addr_q;
    assign fail_xor   = fail_xor_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester: memory model with configurable ack delay, expected write
// stream queued at each pass start and popped on every accepted write.
module tb_mem_pattern_tester;

    localparam logic [31:0] SEED = 32'hACE1_2461;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        mem_req, mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic [31:0] passcount, failcount;
    logic        err_sticky;
    logic [3:0]  fail_addr;
    logic [15:0] fail_xor;
    logic [2:0]  state;

    mem_pattern_tester #(.DATA_W(16), .ADDR_W(4), .ADDR_LAST(4'd15), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .passcount(passcount), .failcount(failcount), .err_sticky(err_sticky),
        .fail_addr(fail_addr), .fail_xor(fail_xor), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [15:0] pat_m(input int md, input int a, input int p, input logic [31:0] l);
        logic [15:0] v;
        case (md)
            0: begin v = 16'(a); if (p % 2 == 1) v = ~v; end
            1: v = l[15:0];
            2: v = 16'h0001 << ((a + p) % 16);
            default: v = (((a ^ p) & 1) == 1) ? 16'hAAAA : 16'h5555;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] mem [16];
    int          dly_max = 0;
    int          cnt = 0;
    bit          spur_en = 0;
    bit          flip_on = 0;
    int          p_m = 0;
    logic [31:0] base_m = SEED;
    int          check_cnt = 0;
    int          rd_cnt = 0;
    logic [2:0]  prev_state = 3'd0;
    bit          waiting = 0;
    logic [3:0]  w_addr = 4'd0;
    logic [15:0] w_data = 16'd0;
    logic        w_we = 1'b0;

    // Memory model and scoreboard; decisions are taken on the falling edge.
    always @(negedge clk) begin
        if (waiting && mem_req) begin
            chk("hold_addr", 32'(mem_addr), 32'(w_addr));
            chk("hold_wdata", 32'(mem_wdata), 32'(w_data));
            chk("hold_we", 32'(mem_we), 32'(w_we));
        end
        if (state == 3'd1 && prev_state != 3'd1) begin
            logic [31:0] l;
            sb.delete();
            l = base_m;
            for (int a = 0; a < 16; a++) begin
                sb.push_back('{a: 4'(a), d: pat_m(int'(mode), a, p_m, l)});
                l = lfsr_nx(l);
            end
        end
        if (state == 3'd3) begin
            chk("sb_left", 32'(sb.size()), 32'd0);
            check_cnt++;
            p_m++;
            base_m = lfsr_nx(base_m);
        end
        prev_state = state;
        if (mem_req) begin
            if (cnt == 0) begin
                mem_ack = 1'b1;
                waiting = 0;
                if (mem_we) begin
                    if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
                    else begin
                        wr_t e;
                        e = sb.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.a));
                        chk("wr_data", 32'(mem_wdata), 32'(e.d));
                    end
                    mem[mem_addr] = mem_wdata;
                end else begin
                    rd_cnt++;
                    mem_rdata = mem[mem_addr];
                    if (flip_on && mem_addr == 4'd5) begin
                        mem_rdata = mem_rdata ^ 16'h0008;
                        flip_on = 0;
                    end
                end
                cnt = int'($urandom_range(0, dly_max));
            end else begin
                mem_ack = 1'b0;
                cnt--;
                waiting = 1;
                w_addr = mem_addr;
                w_data = mem_wdata;
                w_we = mem_we;
            end
        end else begin
            mem_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            waiting = 0;
            cnt = int'($urandom_range(0, dly_max));
        end
    end

    task automatic model_reset();
        sb.delete();
        p_m = 0;
        base_m = SEED;
        check_cnt = 0;
        rd_cnt = 0;
        flip_on = 0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_checks(input int n, input int budget);
        int t = 0;
        while (check_cnt < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (check_cnt < n) chk("timeout_checks", 32'(check_cnt), 32'(n));
    endtask

    task automatic wait_at(input logic [2:0] st, input logic [3:0] a, input int budget);
        int t = 0;
        while (!(state == st && mem_addr == a && mem_ack) && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= budget) chk("timeout_at", 32'(state), 32'(st));
    endtask

    task automatic chk_counts(input string tag, input int pc, input int fc, input logic es);
        chk({tag, "_pass"}, passcount, 32'(pc));
        chk({tag, "_fail"}, failcount, 32'(fc));
        chk({tag, "_err"}, 32'(err_sticky), 32'(es));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_faddr"}, 32'(fail_addr), 32'd0);
        chk({tag, "_fxor"}, 32'(fail_xor), 32'd0);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk_counts(tag, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Address-as-data, three clean passes (pass 1 inverted).
        mode = 2'd0;
        enable = 1'b1;
        wait_checks(3, 400);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_counts("m0", 3, 0, 1'b0);
        chk("m0_idle", 32'(state), 32'd0);

        // LFSR with one corrupted read in pass 0, then a clean pass, then reset mid-write.
        do_reset();
        mode = 2'd1;
        flip_on = 1;
        enable = 1'b1;
        wait_checks(1, 200);
        @(negedge clk);
        #1;
        chk_counts("lf0", 0, 1, 1'b1);
        chk("lf0_faddr", 32'(fail_addr), 32'd5);
        chk("lf0_fxor", 32'(fail_xor), 32'h0008);
        wait_checks(2, 200);
        @(negedge clk);
        #1;
        chk_counts("lf1", 1, 1, 1'b1);
        wait_at(3'd1, 4'd6, 200);
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        wait_checks(1, 200);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_counts("rst_after", 1, 0, 1'b0);

        // Walking one with random ack latency.
        do_reset();
        dly_max = 3;
        mode = 2'd2;
        enable = 1'b1;
        wait_checks(2, 2000);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk_counts("walk", 2, 0, 1'b0);
        dly_max = 0;

        // Abort during READ at address 7, then restart from WRITE address 0.
        do_reset();
        mode = 2'd0;
        enable = 1'b1;
        wait_at(3'd2, 4'd7, 200);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_reads", 32'(rd_cnt), 32'd8);
        chk("abort_checks", 32'(check_cnt), 32'd0);
        chk_counts("abort", 0, 0, 1'b0);
        enable = 1'b1;
        wait_checks(1, 200);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_counts("restart", 1, 0, 1'b0);

        // Checkerboard with stray acks whenever no request is outstanding.
        do_reset();
        mode = 2'd3;
        spur_en = 1;
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("spur_idle_state", 32'(state), 32'd0);
            chk("spur_idle_req", 32'(mem_req), 32'd0);
        end
        enable = 1'b1;
        wait_checks(2, 400);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_counts("cb", 2, 0, 1'b0);
        spur_en = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
